// File: rtl/rv32i_types_pkg.sv
// Shared scalar/vector core types.
// regsel_t : architectural register index (32 registers).
package rv32i_types_pkg;

    localparam int unsigned REGSEL_W = 5;

    typedef logic [REGSEL_W-1:0] regsel_t;

endpackage

// File: rtl/rvv_sb_pkg.sv
// Types and helpers for the vector issue scoreboard.
// sb_state_t : issue controller state (RUN, DRAIN, CFG).
// sb_cnt_w   : counter width able to hold 0..max_val.
// SB_V0_IDX  : index of the mask register v0.
package rvv_sb_pkg;

    import rv32i_types_pkg::*;

    typedef enum logic [1:0] {
        SB_RUN   = 2'd0,
        SB_DRAIN = 2'd1,
        SB_CFG   = 2'd2
    } sb_state_t;

    // Width of a counter that must represent every value in 0..max_val.
    function automatic int unsigned sb_cnt_w(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int unsigned SB_DEF_MAX_INFLIGHT = 4;
    localparam int unsigned SB_CNT_W            = sb_cnt_w(SB_DEF_MAX_INFLIGHT);

    localparam regsel_t SB_V0_IDX = '0;

endpackage

// File: rtl/rvv_issue_scoreboard_if.sv
// Queue-head / execute / writeback / hazard-unit bundle of the vector issue scoreboard.
// master : queue, execute and writeback side (drives the head and completion events).
// slave  : the scoreboard (drives issue_valid, stall_queue, vbusy, inflight, sb_error).
interface rvv_issue_scoreboard_if #(
    parameter int unsigned MAX_INFLIGHT = 4
);
    localparam int unsigned CNT_W = rvv_sb_pkg::sb_cnt_w(MAX_INFLIGHT);

    logic                     q_valid;
    rv32i_types_pkg::regsel_t q_vs1;
    rv32i_types_pkg::regsel_t q_vs2;
    rv32i_types_pkg::regsel_t q_vd;
    logic                     q_vs1_used;
    logic                     q_vs2_used;
    logic                     q_vregwen;
    logic                     q_mask_en;
    logic                     q_vsetvl;
    logic                     ex_ready;
    logic                     wb_valid;
    rv32i_types_pkg::regsel_t wb_vd;
    logic                     cfg_done;
    logic                     flush;

    logic                     issue_valid;
    logic                     stall_queue;
    logic                     vbusy;
    logic [CNT_W-1:0]         inflight;
    logic                     sb_error;

    modport master (
        output q_valid, q_vs1, q_vs2, q_vd, q_vs1_used, q_vs2_used,
               q_vregwen, q_mask_en, q_vsetvl, ex_ready, wb_valid, wb_vd,
               cfg_done, flush,
        input  issue_valid, stall_queue, vbusy, inflight, sb_error
    );

    modport slave (
        input  q_valid, q_vs1, q_vs2, q_vd, q_vs1_used, q_vs2_used,
               q_vregwen, q_mask_en, q_vsetvl, ex_ready, wb_valid, wb_vd,
               cfg_done, flush,
        output issue_valid, stall_queue, vbusy, inflight, sb_error
    );

endinterface

// File: rtl/vreg_pending_counter.sv
// Per-register outstanding-write counter, saturating at MAX_COUNT.
// CLK, nRST : clock, asynchronous active-low reset
// inc       : an op writing this register issues
// dec       : a writeback to this register completes
// is_zero   : registered, counter is 0
// underflow : decrement requested with the counter already at 0 (no matching issue)
module vreg_pending_counter
    import rvv_sb_pkg::*;
#(
    parameter int unsigned MAX_COUNT = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic inc,
    input  logic dec,
    output logic is_zero,
    output logic underflow
);
    localparam int unsigned CNT_W = sb_cnt_w(MAX_COUNT);

    logic [CNT_W-1:0] count_q;

    // A same-cycle inc/dec pair cancels, so it can never underflow.
    assign underflow = dec && !inc && is_zero;

    // Counter with zero flag kept alongside so hazard checks see a flop.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_q <= '0;
            is_zero <= 1'b1;
        end else if (inc && !dec && (count_q != CNT_W'(MAX_COUNT))) begin
            count_q <= count_q + CNT_W'(1);
            is_zero <= 1'b0;
        end else if (dec && !inc && (count_q != '0)) begin
            count_q <= count_q - CNT_W'(1);
            is_zero <= (count_q == CNT_W'(1));
        end
    end

endmodule

// File: rtl/rvv_issue_scoreboard.sv
// Vector issue controller: tracks outstanding vector-register writes, holds the
// queue head on RAW/WAW hazards or a full in-flight budget, and serializes vsetvl.
// CLK, nRST : clock, asynchronous active-low reset
// sb        : slave side of rvv_issue_scoreboard_if (head, execute ready,
//             writeback, cfg_done, flush in; issue_valid, stall_queue, vbusy,
//             inflight, sb_error out)
// Build option RVV_SB_MASK_HAZARD_EN: masked ops also wait on pending v0 writes.
module rvv_issue_scoreboard
    import rv32i_types_pkg::*;
    import rvv_sb_pkg::*;
#(
    parameter int unsigned NUM_VREGS    = 32,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                 CLK,
    input  logic                 nRST,
    rvv_issue_scoreboard_if.slave sb
);
    localparam int unsigned CNT_W = sb_cnt_w(MAX_INFLIGHT);

    sb_state_t            state_q;
    sb_state_t            state_d;
    logic [CNT_W-1:0]     inflight_q;
    logic [CNT_W-1:0]     inflight_d;
    logic                 vbusy_q;
    logic                 err_q;

    logic                 issue;
    logic                 hazard;
    logic                 inc_any;
    logic                 dec_ok;
    logic                 inflight_zero;
    logic                 inflight_room;

    logic [NUM_VREGS-1:0] pend_zero;
    logic [NUM_VREGS-1:0] underflow_vec;
    logic [NUM_VREGS-1:0] inc_vec;
    logic [NUM_VREGS-1:0] dec_vec;

    assign inflight_zero = (inflight_q == '0);
    assign inflight_room = (inflight_q < CNT_W'(MAX_INFLIGHT));

    // vsetvl only touches vl/vtype, so it never owns a pending write.
    assign inc_any = issue && sb.q_vregwen && !sb.q_vsetvl;
    // A spurious writeback is dropped rather than decrementing inflight.
    assign dec_ok  = sb.wb_valid && !underflow_vec[sb.wb_vd];

    // One pending counter per architectural vector register.
    for (genvar i = 0; i < NUM_VREGS; i++) begin : g_pend
        assign inc_vec[i] = inc_any && (sb.q_vd == regsel_t'(i));
        assign dec_vec[i] = sb.wb_valid && (sb.wb_vd == regsel_t'(i));

        vreg_pending_counter #(
            .MAX_COUNT (MAX_INFLIGHT)
        ) u_cnt (
            .CLK       (CLK),
            .nRST      (nRST),
            .inc       (inc_vec[i]),
            .dec       (dec_vec[i]),
            .is_zero   (pend_zero[i]),
            .underflow (underflow_vec[i])
        );
    end

    // RAW on either source, WAW on the destination, optionally v0 for masking.
    always_comb begin
        hazard = (sb.q_vs1_used && !pend_zero[sb.q_vs1]) ||
                 (sb.q_vs2_used && !pend_zero[sb.q_vs2]) ||
                 (sb.q_vregwen  && !pend_zero[sb.q_vd]);
`ifdef RVV_SB_MASK_HAZARD_EN
        hazard = hazard || (sb.q_mask_en && !pend_zero[SB_V0_IDX]);
`endif
    end

    // Next state and issue decision.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            SB_RUN: begin
                if (sb.q_valid && !sb.flush) begin
                    if (sb.q_vsetvl) begin
                        if (inflight_zero && sb.ex_ready) begin
                            issue   = 1'b1;
                            state_d = SB_CFG;
                        end else begin
                            state_d = SB_DRAIN;
                        end
                    end else begin
                        issue = sb.ex_ready && !hazard && inflight_room;
                    end
                end
            end
            SB_DRAIN: begin
                // Flush removes the waiting vsetvl; nothing was committed yet.
                if (sb.flush) begin
                    state_d = SB_RUN;
                end else if (sb.q_valid && inflight_zero && sb.ex_ready) begin
                    issue   = 1'b1;
                    state_d = SB_CFG;
                end
            end
            SB_CFG: begin
                // Issued vsetvl is committed, so flush does not leave CFG.
                if (sb.cfg_done) begin
                    state_d = SB_RUN;
                end
            end
            default: state_d = SB_RUN;
        endcase
    end

    // Total outstanding writes; simultaneous issue and retire cancel.
    always_comb begin
        inflight_d = inflight_q;
        if (inc_any && !dec_ok) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!inc_any && dec_ok) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= SB_RUN;
            inflight_q <= '0;
            vbusy_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            vbusy_q    <= (inflight_d != '0) || (state_d != SB_RUN);
            err_q      <= err_q || (|underflow_vec);
        end
    end

    assign sb.issue_valid = issue;
    assign sb.stall_queue = sb.q_valid && !issue;
    assign sb.vbusy       = vbusy_q;
    assign sb.inflight    = inflight_q;
    assign sb.sb_error    = err_q;

endmodule

// File: tb/tb_rvv_issue_scoreboard.sv
// Scoreboard bench for rvv_issue_scoreboard: directed scenarios then random traffic,
// all checked against a register-level behavioural model of the issue rules.
module tb_rvv_issue_scoreboard;

    localparam int MAXI = 4;
    localparam int ST_RUN = 0, ST_DRAIN = 1, ST_CFG = 2;

    typedef struct {
        bit valid; int vs1; int vs2; int vd; bit vs1u; bit vs2u; bit wen;
        bit mask; bit vsetvl; bit ex_ready; bit wb_valid; int wb_vd;
        bit cfg_done; bit flush;
    } stim_t;

    typedef struct {
        bit issue; bit stall; bit vbusy; bit err; int infl; int cyc;
    } exp_t;

    logic CLK;
    logic nRST;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    exp_t comb_q[$];
    exp_t reg_q[$];

    // Behavioural model state
    int   pend[32];
    int   m_infl;
    int   m_state;
    bit   m_err;
    int   out_q[$];
    bit   last_issued;

    rvv_issue_scoreboard_if #(.MAX_INFLIGHT(MAXI)) sbif ();

    rvv_issue_scoreboard #(
        .NUM_VREGS    (32),
        .MAX_INFLIGHT (MAXI)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .sb   (sbif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Combinational outputs: checked mid-cycle for the stimulus just applied.
    initial forever begin
        exp_t e;
        @(negedge CLK);
        if (comb_q.size() > 0) begin
            e = comb_q.pop_front();
            check("issue_valid", int'(sbif.issue_valid), int'(e.issue));
            check("stall_queue", int'(sbif.stall_queue), int'(e.stall));
        end
    end

    // Registered outputs: checked once the edge ending that cycle has passed.
    initial forever begin
        exp_t e;
        @(posedge CLK);
        #2;
        while (reg_q.size() > 0 && reg_q[0].cyc < cyc) begin
            e = reg_q.pop_front();
            check("inflight", int'(sbif.inflight), e.infl);
            check("vbusy",    int'(sbif.vbusy),    int'(e.vbusy));
            check("sb_error", int'(sbif.sb_error), int'(e.err));
        end
    end

    function automatic stim_t idle();
        stim_t s;
        s = '{valid: 0, vs1: 0, vs2: 0, vd: 0, vs1u: 0, vs2u: 0, wen: 0, mask: 0,
              vsetvl: 0, ex_ready: 1, wb_valid: 0, wb_vd: 0, cfg_done: 0, flush: 0};
        return s;
    endfunction

    function automatic stim_t op(input int vd, input int vs1, input int vs2,
                                 input bit vs1u, input bit vs2u, input bit wen);
        stim_t s;
        s = idle();
        s.valid = 1; s.vd = vd; s.vs1 = vs1; s.vs2 = vs2;
        s.vs1u = vs1u; s.vs2u = vs2u; s.wen = wen;
        return s;
    endfunction

    function automatic stim_t vset();
        stim_t s;
        s = idle();
        s.valid = 1; s.vsetvl = 1;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        sbif.q_valid    = s.valid;
        sbif.q_vs1      = 5'(s.vs1);
        sbif.q_vs2      = 5'(s.vs2);
        sbif.q_vd       = 5'(s.vd);
        sbif.q_vs1_used = s.vs1u;
        sbif.q_vs2_used = s.vs2u;
        sbif.q_vregwen  = s.wen;
        sbif.q_mask_en  = s.mask;
        sbif.q_vsetvl   = s.vsetvl;
        sbif.ex_ready   = s.ex_ready;
        sbif.wb_valid   = s.wb_valid;
        sbif.wb_vd      = 5'(s.wb_vd);
        sbif.cfg_done   = s.cfg_done;
        sbif.flush      = s.flush;
    endtask

    function automatic void model_clear();
        foreach (pend[i]) pend[i] = 0;
        m_infl  = 0;
        m_state = ST_RUN;
        m_err   = 0;
        out_q.delete();
    endfunction

    // Apply one cycle of stimulus and predict its effect from the issue rules.
    task automatic drive_cycle(input stim_t s);
        exp_t e;
        bit   hz;
        bit   iss;
        int   ns;
        @(posedge CLK);
        #1;
        apply(s);
        hz = (s.vs1u && pend[s.vs1] != 0) || (s.vs2u && pend[s.vs2] != 0) ||
             (s.wen && pend[s.vd] != 0);
`ifdef RVV_SB_MASK_HAZARD_EN
        hz = hz || (s.mask && pend[0] != 0);
`endif
        iss = 0;
        ns  = m_state;
        if (m_state == ST_RUN) begin
            if (s.valid && !s.flush) begin
                if (s.vsetvl) begin
                    if (m_infl == 0 && s.ex_ready) begin iss = 1; ns = ST_CFG; end
                    else ns = ST_DRAIN;
                end else begin
                    iss = s.ex_ready && !hz && (m_infl < MAXI);
                end
            end
        end else if (m_state == ST_DRAIN) begin
            if (s.flush) ns = ST_RUN;
            else if (s.valid && m_infl == 0 && s.ex_ready) begin iss = 1; ns = ST_CFG; end
        end else begin
            if (s.cfg_done) ns = ST_RUN;
        end
        if (iss && s.wen && !s.vsetvl) begin
            pend[s.vd]++;
            m_infl++;
            out_q.push_back(s.vd);
        end
        if (s.wb_valid) begin
            if (pend[s.wb_vd] == 0) begin
                m_err = 1;
            end else begin
                pend[s.wb_vd]--;
                m_infl--;
                foreach (out_q[k]) begin
                    if (out_q[k] == s.wb_vd) begin
                        out_q.delete(k);
                        break;
                    end
                end
            end
        end
        m_state     = ns;
        last_issued = iss;
        e.issue = iss;
        e.stall = s.valid && !iss;
        e.infl  = m_infl;
        e.vbusy = (m_infl != 0) || (m_state != ST_RUN);
        e.err   = m_err;
        e.cyc   = cyc;
        comb_q.push_back(e);
        reg_q.push_back(e);
    endtask

    // Retire everything outstanding and return to RUN.
    task automatic settle();
        stim_t s;
        for (int k = 0; k < 64 && (out_q.size() > 0 || m_state != ST_RUN); k++) begin
            s = idle();
            if (out_q.size() > 0) begin s.wb_valid = 1; s.wb_vd = out_q[0]; end
            if (m_state == ST_CFG)   s.cfg_done = 1;
            if (m_state == ST_DRAIN) s.flush = 1;
            drive_cycle(s);
        end
        check("settle_idle", int'(out_q.size() == 0 && m_state == ST_RUN), 1);
    endtask

    // Reset in the middle of a cycle, after all pending checks were consumed.
    task automatic do_reset();
        drive_cycle(idle());
        @(posedge CLK);
        #3;
        nRST = 1'b0;
        #1;
        check("rst_issue_valid", int'(sbif.issue_valid), 0);
        check("rst_stall_queue", int'(sbif.stall_queue), 0);
        check("rst_vbusy",       int'(sbif.vbusy),       0);
        check("rst_inflight",    int'(sbif.inflight),    0);
        check("rst_sb_error",    int'(sbif.sb_error),    0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        model_clear();
    endtask

    initial begin
        stim_t s;
        stim_t hd;
        bit    have;
        int    idx;
        bit    vs_done;

        nRST = 1'b0;
        apply(idle());
        sbif.q_valid = 1'b0;
        model_clear();
        repeat (3) @(posedge CLK);
        #3;
        check("init_issue_valid", int'(sbif.issue_valid), 0);
        check("init_stall_queue", int'(sbif.stall_queue), 0);
        check("init_vbusy",       int'(sbif.vbusy),       0);
        check("init_inflight",    int'(sbif.inflight),    0);
        check("init_sb_error",    int'(sbif.sb_error),    0);
        @(negedge CLK);
        nRST = 1'b1;

        // RAW on v3: reader waits until the cycle after the writeback.
        drive_cycle(op(3, 0, 0, 0, 0, 1));
        s = op(10, 3, 4, 1, 1, 0);
        repeat (3) drive_cycle(s);
        s.wb_valid = 1; s.wb_vd = 3;
        drive_cycle(s);
        check("raw_no_bypass", int'(last_issued), 0);
        drive_cycle(op(10, 3, 4, 1, 1, 0));
        check("raw_issue_after_wb", int'(last_issued), 1);
        settle();

        // In-flight budget: fifth writer waits for the first writeback.
        idx = 1;
        for (int c = 0; c < 9; c++) begin
            s = (idx <= 5) ? op(idx, 20, 21, 0, 0, 1) : idle();
            if (c == 5) begin s.wb_valid = 1; s.wb_vd = 1; end
            drive_cycle(s);
            if (last_issued) idx++;
        end
        check("budget_all_issued", idx, 6);
        settle();

        // vsetvl drains two in-flight ops, waits in CFG, then RUN resumes.
        drive_cycle(op(10, 0, 0, 0, 0, 1));
        drive_cycle(op(11, 0, 0, 0, 0, 1));
        vs_done = 0;
        for (int c = 0; c < 12; c++) begin
            s = vs_done ? op(12, 0, 0, 0, 0, 1) : vset();
            if (c == 2) begin s.wb_valid = 1; s.wb_vd = 10; end
            if (c == 4) begin s.wb_valid = 1; s.wb_vd = 11; end
            if (c == 8) s.cfg_done = 1;
            drive_cycle(s);
            if (last_issued) vs_done = 1;
        end
        settle();

        // Same-cycle issue and writeback: inflight holds; WAW on v7 waits.
        drive_cycle(op(7, 0, 0, 0, 0, 1));
        drive_cycle(op(8, 0, 0, 0, 0, 1));
        s = op(9, 0, 0, 0, 0, 1);
        s.wb_valid = 1; s.wb_vd = 8;
        drive_cycle(s);
        s = op(7, 0, 0, 0, 0, 1);
        s.wb_valid = 1; s.wb_vd = 7;
        drive_cycle(s);
        drive_cycle(op(7, 0, 0, 0, 0, 1));
        settle();

        // Writeback with no pending write sets the sticky error.
        s = idle(); s.wb_valid = 1; s.wb_vd = 9;
        drive_cycle(s);
        repeat (3) drive_cycle(idle());
        do_reset();

        // Reset mid-operation, then the old op's writeback is spurious.
        drive_cycle(op(12, 0, 0, 0, 0, 1));
        drive_cycle(op(13, 0, 0, 0, 0, 1));
        do_reset();
        s = idle(); s.wb_valid = 1; s.wb_vd = 12;
        drive_cycle(s);
        drive_cycle(idle());
        do_reset();

        // Masked op while v0 has a pending write.
        drive_cycle(op(0, 0, 0, 0, 0, 1));
        s = op(20, 21, 22, 1, 1, 1);
        s.mask = 1;
        drive_cycle(s);
        if (!last_issued) begin
            drive_cycle(s);
            s.wb_valid = 1; s.wb_vd = 0;
            drive_cycle(s);
            s.wb_valid = 0;
            drive_cycle(s);
        end
        settle();

        // Flush while draining for vsetvl returns to RUN without issuing.
        drive_cycle(op(4, 0, 0, 0, 0, 1));
        drive_cycle(vset());
        s = vset(); s.flush = 1;
        drive_cycle(s);
        drive_cycle(idle());
        settle();

        // Random traffic over a small register window to provoke hazards.
        have = 0;
        hd   = idle();
        for (int c = 0; c < 3000; c++) begin
            if (!have) begin
                hd = op($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 3) != 0);
                hd.mask   = ($urandom_range(0, 3) == 0);
                hd.vsetvl = ($urandom_range(0, 15) == 0);
                if (hd.vsetvl) hd.wen = 0;
                hd.valid  = ($urandom_range(0, 9) != 0);
                have = 1;
            end
            s = hd;
            s.ex_ready = ($urandom_range(0, 4) != 0);
            s.flush    = ($urandom_range(0, 15) == 0);
            s.cfg_done = (m_state == ST_CFG) ? ($urandom_range(0, 2) == 0)
                                             : ($urandom_range(0, 31) == 0);
            if (out_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                s.wb_valid = 1;
                s.wb_vd    = out_q[$urandom_range(0, out_q.size() - 1)];
            end
            drive_cycle(s);
            if (last_issued || s.flush || !s.valid) have = 0;
        end
        settle();

        @(posedge CLK);
        #3;
        check("queues_drained", comb_q.size() + reg_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
